// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with a hardware clear engine.
// After reset, or on a CLEAR pulse while idle, the clear engine writes CLR_VAL
// to every implemented word, one word per cycle. While the sweep runs, BUSY is
// high and READ/WRITE strobes are dropped.
// Reads are registered and have a one-cycle latency. RVALID marks each read
// result. ADDR_ERR flags any accepted access whose address is >= DEPTH.
module ram_sync_clr #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 5,
  parameter int                DEPTH    = 32,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              CLEAR,
  input  logic              WRITE,
  input  logic              READ,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              RVALID,
  output logic              ADDR_ERR,
  output logic              BUSY
);

  // The compare is one bit wider than the address, so DEPTH == 2**ADDR_W is
  // representable and every address counts as in range.
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              busy_q;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              accept_p0;
  logic              in_range_p0;
  logic              wr_p0;
  logic              rd_p0;
  logic [DATA_W-1:0] rdata_p0;

  // Input stage: decode the access that is accepted at this edge.
  assign accept_p0   = (state == IDLE) && (READ || WRITE);
  assign in_range_p0 = ({1'b0, ADDR} < DEPTH_W);
  assign wr_p0       = (state == IDLE) && WRITE && in_range_p0;
  assign rd_p0       = (state == IDLE) && READ;
  assign BUSY        = busy_q;

  // Read data selection.
  // Out-of-range reads return the fill value.
  // When a read and a write hit the same word in one cycle, RDW_MODE picks
  // the new data (1) or the array contents (0).
  always_comb begin
    rdata_p0 = CLR_VAL;
    if (in_range_p0) begin
      if (WRITE && (RDW_MODE != 0)) rdata_p0 = DATA_IN;
      else                          rdata_p0 = mem[ADDR];
    end
  end

  // Clear-engine FSM.
  // The sweep finishes on the edge that writes the last word, so it takes
  // exactly DEPTH cycles.
  // CLEAR is sampled only in IDLE, so a CLEAR during a sweep is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLR;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        CLR: begin
          if (clr_cnt == LAST_IDX) begin
            state   <= IDLE;
            clr_cnt <= '0;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          if (CLEAR) begin
            state   <= CLR;
            clr_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Array write port, shared by the clear engine and accepted writes.
  // The array has no reset; its contents are defined only by the sweep.
  always_ff @(posedge clk) begin
    if (state == CLR)  mem[clr_cnt] <= CLR_VAL;
    else if (wr_p0)    mem[ADDR]    <= DATA_IN;
  end

  // Output stage: registered read data and the one-cycle status pulses.
  // DATA_OUT holds its value across cycles with no accepted read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      DATA_OUT <= '0;
      RVALID   <= 1'b0;
      ADDR_ERR <= 1'b0;
    end else begin
      RVALID   <= rd_p0;
      ADDR_ERR <= accept_p0 && !in_range_p0;
      if (rd_p0) DATA_OUT <= rdata_p0;
    end
  end

endmodule

// File: tb/tb_ram_sync_clr.sv
// Randomised scoreboard bench for ram_sync_clr.
// Two instances share one stimulus stream:
//   dut0: DEPTH=32, RDW_MODE=0, CLR_VAL=0x00
//   dut1: DEPTH=20, RDW_MODE=1, CLR_VAL=0xA5
// Each instance has a behavioural model: a word array, a count of sweep
// cycles remaining, and the last value read.
module tb_ram_sync_clr;

  typedef struct packed {
    logic       rv;
    logic       ae;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       clr;
  logic       wr;
  logic       rd;
  logic [4:0] addr;
  logic [7:0] din;

  logic [7:0] dout0, dout1;
  logic       rv0, rv1, ae0, ae1, bz0, bz1;

  int checks   = 0;
  int failures = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mm       [2][32];
  int         clr_left [2];
  logic [7:0] dout_m   [2];

  ram_sync_clr #(
    .DATA_W(8), .ADDR_W(5), .DEPTH(32), .RDW_MODE(0), .CLR_VAL(8'h00)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .CLEAR(clr), .WRITE(wr), .READ(rd),
    .ADDR(addr), .DATA_IN(din), .DATA_OUT(dout0), .RVALID(rv0),
    .ADDR_ERR(ae0), .BUSY(bz0)
  );

  ram_sync_clr #(
    .DATA_W(8), .ADDR_W(5), .DEPTH(20), .RDW_MODE(1), .CLR_VAL(8'hA5)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .CLEAR(clr), .WRITE(wr), .READ(rd),
    .ADDR(addr), .DATA_IN(din), .DATA_OUT(dout1), .RVALID(rv1),
    .ADDR_ERR(ae1), .BUSY(bz1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(input int id);
    return (id == 0) ? 32 : 20;
  endfunction

  function automatic logic [7:0] cv(input int id);
    return (id == 0) ? 8'h00 : 8'hA5;
  endfunction

  function automatic bit rdw_new(input int id);
    return (id == 1);
  endfunction

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t",
               nm, id, act, exp, $time);
    end
  endtask

  // One clock edge of the reference model.
  // The sweep is modelled as "busy for DEPTH edges, then every word holds
  // the fill value".
  task automatic model_step(input int id, output bit push, output exp_t it);
    bit inr;
    push = 1'b0;
    it   = '0;
    inr  = (int'(addr) < dep(id));
    if (!reset_n) begin
      clr_left[id] = dep(id);
      dout_m[id]   = 8'h00;
    end else if (clr_left[id] > 0) begin
      clr_left[id]--;
      if (clr_left[id] == 0)
        for (int i = 0; i < 32; i++) mm[id][i] = cv(id);
    end else begin
      if (rd) begin
        it.rv = 1'b1;
        it.ae = !inr;
        if (!inr)                  it.data = cv(id);
        else if (wr && rdw_new(id)) it.data = din;
        else                       it.data = mm[id][addr];
        dout_m[id] = it.data;
        push = 1'b1;
      end else if (wr && !inr) begin
        it.ae = 1'b1;
        push  = 1'b1;
      end
      if (wr && inr) mm[id][addr] = din;
      if (clr) clr_left[id] = dep(id);
    end
  endtask

  // Model side: predict each edge and queue the expected responses.
  always @(posedge clk) begin
    bit   p;
    exp_t it;
    model_step(0, p, it);
    if (p) q0.push_back(it);
    model_step(1, p, it);
    if (p) q1.push_back(it);
  end

  task automatic check_dut(input int id, input logic rv, input logic ae,
                           input logic [7:0] d, input logic b);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '0;
    chk("busy", id, b, clr_left[id] > 0);
    chk("data_out", id, d, dout_m[id]);
    if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    if (have) begin
      chk("rvalid", id, rv, e.rv);
      chk("addr_err", id, ae, e.ae);
    end else begin
      chk("rvalid_idle", id, rv, 1'b0);
      chk("addr_err_idle", id, ae, 1'b0);
    end
  endtask

  // Monitor side: compare DUT outputs on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      check_dut(0, rv0, ae0, dout0, bz0);
      check_dut(1, rv1, ae1, dout1, bz1);
    end
  end

  task automatic access(input bit c, input bit w, input bit r,
                        input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    #1;
    clr  = c;
    wr   = w;
    rd   = r;
    addr = a;
    din  = d;
  endtask

  task automatic check_reset_outputs();
    chk("rst_data_out", 0, dout0, 8'h00);
    chk("rst_rvalid",   0, rv0,   1'b0);
    chk("rst_addr_err", 0, ae0,   1'b0);
    chk("rst_busy",     0, bz0,   1'b1);
    chk("rst_data_out", 1, dout1, 8'h00);
    chk("rst_rvalid",   1, rv1,   1'b0);
    chk("rst_addr_err", 1, ae1,   1'b0);
    chk("rst_busy",     1, bz1,   1'b1);
  endtask

  // Count edges until each instance drops BUSY, with a fixed bound.
  task automatic wait_idle(output int n0, output int n1);
    n0 = -1;
    n1 = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (n0 < 0 && !bz0) n0 = k;
      if (n1 < 0 && !bz1) n1 = k;
      if (n0 >= 0 && n1 >= 0) break;
    end
    if (n0 < 0 || n1 < 0) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: BUSY still high after 100 cycles (n0=%0d n1=%0d)",
               n0, n1);
    end
  endtask

  initial begin
    int n0, n1;
    reset_n = 1'b0;
    clr = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; din = '0;
    for (int i = 0; i < 2; i++) begin
      clr_left[i] = dep(i);
      dout_m[i]   = 8'h00;
      for (int j = 0; j < 32; j++) mm[i][j] = cv(i);
    end

    repeat (3) access(0, 0, 0, 5'd0, 8'h00);
    check_reset_outputs();
    reset_n = 1'b1;
    wait_idle(n0, n1);
    chk("sweep_len", 0, n0, 32);
    chk("sweep_len", 1, n1, 20);

    for (int a = 0; a < 32; a++) access(0, 0, 1, 5'(a), 8'h00);
    access(0, 1, 0, 5'd3, 8'h5A);
    access(0, 0, 1, 5'd3, 8'h00);
    access(0, 0, 0, 5'd0, 8'h00);
    access(0, 1, 0, 5'd7, 8'h11);
    access(0, 1, 1, 5'd7, 8'h22);
    access(0, 0, 1, 5'd7, 8'h00);
    access(0, 1, 0, 5'd25, 8'hFF);
    access(0, 0, 1, 5'd25, 8'h00);
    for (int a = 0; a < 20; a++) access(0, 0, 1, 5'(a), 8'h00);

    // A clear sweep after writes; reads issued while busy must be dropped.
    access(1, 0, 0, 5'd0, 8'h00);
    for (int i = 0; i < 5; i++) access(0, 0, 1, 5'($urandom_range(0, 31)), 8'h00);
    access(0, 0, 0, 5'd0, 8'h00);
    wait_idle(n0, n1);
    for (int a = 0; a < 32; a++) access(0, 0, 1, 5'(a), 8'h00);

    // Abort a sweep with reset while DATA_OUT is non-zero.
    access(0, 1, 0, 5'd2, 8'h3C);
    access(0, 0, 1, 5'd2, 8'h00);
    access(1, 0, 0, 5'd0, 8'h00);
    repeat (10) access(0, 0, 0, 5'd0, 8'h00);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) access(0, 0, 0, 5'd0, 8'h00);
    reset_n = 1'b1;
    wait_idle(n0, n1);
    chk("sweep_len_after_abort", 0, n0, 32);
    chk("sweep_len_after_abort", 1, n1, 20);

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 1500; i++) begin
      access(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 9) < 4),
             ($urandom_range(0, 1) == 1),
             5'($urandom_range(0, 31)),
             8'($urandom));
    end
    repeat (3) access(0, 0, 0, 5'd0, 8'h00);
    chk("queue_drained", 0, q0.size(), 0);
    chk("queue_drained", 1, q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
